id_scanner: RTL and testbench
=============================

ID_SCANNER -- requirements
Module: id_scanner

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum accepted identifier length in characters (legal range 2..255).
REQ-002 Parameter ALLOW_US, default 1, SHALL make underscore (8'h5F) count as a letter when 1 and as a delimiter when 0.
REQ-003 Localparam LEN_W SHALL equal $clog2(MAX_LEN+1).
REQ-004 clk  input  1  Sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-high reset.
REQ-006 in_valid  input  1  Qualifies char for the current cycle.
REQ-007 char  input  8  ASCII character.
REQ-008 id_digit  output  1  Registered; digit accepted inside an identifier.
REQ-009 tok_valid  output  1  Registered one-cycle pulse; identifier completed.
REQ-010 tok_len  output  LEN_W  Length of the last completed identifier.
REQ-011 tok_ovf  output  1  Registered one-cycle pulse; identifier exceeded MAX_LEN.

Function
REQ-012 Classification: letter = 8'h41..8'h5A or 8'h61..8'h7A (plus 8'h5F if ALLOW_US); digit = 8'h30..8'h39; everything else = delimiter.
REQ-013 States: IDLE, IDENT, NUMBER, SKIP; an internal counter len (LEN_W bits) SHALL track the current identifier length.
REQ-014 A cycle with in_valid=0 SHALL hold state, len and tok_len, and SHALL drive id_digit, tok_valid and tok_ovf to 0 at the next edge.
REQ-015 IDLE: letter -> IDENT with len=1; digit -> NUMBER; delimiter -> IDLE.
REQ-016 IDENT with len<MAX_LEN: letter or digit -> IDENT, len+1; a digit SHALL also set id_digit=1 for one cycle.
REQ-017 IDENT with len==MAX_LEN: letter or digit -> SKIP with tok_ovf=1 for one cycle and id_digit=0.
REQ-018 IDENT: delimiter -> IDLE, tok_valid=1 and tok_len=len at the same edge.
REQ-019 NUMBER: letter or digit -> NUMBER (no identifier starts mid-number); delimiter -> IDLE; no token output.
REQ-020 SKIP: letter or digit -> SKIP; delimiter -> IDLE; tok_valid SHALL stay 0 for the overflowed word.
REQ-021 Latency: every output SHALL reflect the character accepted at the preceding rising edge (one cycle).
REQ-022 tok_len SHALL hold its value until the next tok_valid pulse.
REQ-023 tok_valid and tok_ovf SHALL never be 1 in the same cycle.
REQ-024 len SHALL never wrap; it saturates into SKIP per REQ-017.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, len=0, id_digit=0, tok_valid=0, tok_len=0, tok_ovf=0 regardless of clk.
REQ-026 Reset asserted mid-identifier SHALL discard it; no tok_valid is produced for it after release.
REQ-027 The first valid character after reset release SHALL be classified from IDLE.

Structure
REQ-028 State encoding enum and ASCII range constants (letter, digit, underscore bounds) SHALL live in the shared package lex_pkg.
REQ-029 Character classification SHALL be a separate combinational sub-module char_class (outputs is_letter, is_digit; ALLOW_US parameter).
REQ-030 The FSM, length counter and output registers SHALL reside in id_scanner.

Verification
REQ-031 Stream "ab12 " (in_valid=1) -> id_digit=1 on the cycles after '1' and '2'; tok_valid=1 with tok_len=4 the cycle after ' '.
REQ-032 Stream "9ab " -> id_digit, tok_valid and tok_ovf all remain 0.
REQ-033 MAX_LEN=4, stream "abcde1 " -> tok_ovf=1 the cycle after 'e', tok_valid never 1, state IDLE after ' '.
REQ-034 ALLOW_US=0, stream "a_b " -> tok_valid with tok_len=1 after '_', then tok_valid with tok_len=1 after ' '; ALLOW_US=1 -> single tok_valid, tok_len=3.
REQ-035 "ab" then in_valid=0 for 3 cycles, then " " -> outputs 0 during the gap; tok_valid, tok_len=2 after ' '.
REQ-036 "abc" then reset pulse mid-cycle then " x " -> all outputs 0 immediately on reset; only one tok_valid, tok_len=1, for "x".

Source files
------------

// File: rtl/lex_pkg.sv
// Shared lexer definitions: scanner state encoding and ASCII class boundaries.
package lex_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IDENT  = 2'd1,
        NUMBER = 2'd2,
        SKIP   = 2'd3
    } state_t;

    localparam logic [7:0] UPPER_LO   = 8'h41;
    localparam logic [7:0] UPPER_HI   = 8'h5A;
    localparam logic [7:0] LOWER_LO   = 8'h61;
    localparam logic [7:0] LOWER_HI   = 8'h7A;
    localparam logic [7:0] DIGIT_LO   = 8'h30;
    localparam logic [7:0] DIGIT_HI   = 8'h39;
    localparam logic [7:0] UNDERSCORE = 8'h5F;

endpackage

// File: rtl/id_scanner_if.sv
// Character stream in, identifier token results out.
interface id_scanner_if #(
    parameter int LEN_W = 5
);
    logic             in_valid;
    logic [7:0]       char;
    logic             id_digit;
    logic             tok_valid;
    logic [LEN_W-1:0] tok_len;
    logic             tok_ovf;

    modport master (
        output in_valid, char,
        input  id_digit, tok_valid, tok_len, tok_ovf
    );

    modport slave (
        input  in_valid, char,
        output id_digit, tok_valid, tok_len, tok_ovf
    );
endinterface

// File: rtl/id_scanner_char_class.sv
// Combinational ASCII classifier: letter, digit, or (neither) delimiter.
module char_class
    import lex_pkg::*;
#(
    parameter int ALLOW_US = 1
) (
    input  logic [7:0] char,
    output logic       is_letter,
    output logic       is_digit
);

    logic us_letter;

    // Underscore joins identifiers only when enabled; otherwise it splits them.
    assign us_letter = (ALLOW_US != 0) && (char == UNDERSCORE);

    assign is_letter = ((char >= UPPER_LO) && (char <= UPPER_HI)) ||
                       ((char >= LOWER_LO) && (char <= LOWER_HI)) ||
                       us_letter;
    assign is_digit  = (char >= DIGIT_LO) && (char <= DIGIT_HI);

endmodule

// File: rtl/id_scanner.sv
// Identifier scanner: reports identifier lengths, digits inside identifiers,
// and identifiers longer than MAX_LEN, one cycle after each accepted character.
module id_scanner
    import lex_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int ALLOW_US = 1
) (
    input  logic         clk,
    input  logic         reset,
    id_scanner_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic             is_letter;
    logic             is_digit;
    logic             is_word;

    char_class #(
        .ALLOW_US (ALLOW_US)
    ) u_class (
        .char      (bus.char),
        .is_letter (is_letter),
        .is_digit  (is_digit)
    );

    assign is_word = is_letter || is_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len           <= '0;
            bus.id_digit  <= 1'b0;
            bus.tok_valid <= 1'b0;
            bus.tok_len   <= '0;
            bus.tok_ovf   <= 1'b0;
        end else begin
            bus.id_digit  <= 1'b0;
            bus.tok_valid <= 1'b0;
            bus.tok_ovf   <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    IDLE: begin
                        if (is_letter) begin
                            state <= IDENT;
                            len   <= LEN_W'(1);
                        end else if (is_digit) begin
                            state <= NUMBER;
                        end
                    end
                    IDENT: begin
                        if (is_word) begin
                            // A full-length identifier is abandoned rather than wrapped.
                            if (len == LEN_W'(MAX_LEN)) begin
                                state       <= SKIP;
                                bus.tok_ovf <= 1'b1;
                            end else begin
                                len          <= len + LEN_W'(1);
                                bus.id_digit <= is_digit;
                            end
                        end else begin
                            state         <= IDLE;
                            len           <= '0;
                            bus.tok_valid <= 1'b1;
                            bus.tok_len   <= len;
                        end
                    end
                    NUMBER, SKIP: begin
                        if (!is_word) begin
                            state <= IDLE;
                            len   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        len   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_id_scanner.sv
// Bench for id_scanner: three configurations share one character stream and
// are each checked against a word-level reference model.
module tb_id_scanner;

    logic clk;
    logic reset;

    id_scanner_if #(.LEN_W(5)) if_a ();
    id_scanner_if #(.LEN_W(3)) if_b ();
    id_scanner_if #(.LEN_W(5)) if_c ();

    id_scanner #(.MAX_LEN(16), .ALLOW_US(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    id_scanner #(.MAX_LEN(4),  .ALLOW_US(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    id_scanner #(.MAX_LEN(16), .ALLOW_US(0)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state per configuration
    int maxl [3] = '{16, 4, 16};
    bit us   [3] = '{1'b1, 1'b1, 1'b0};
    int wlen [3];
    bit ident[3];
    int etl  [3];
    bit eid  [3];
    bit etv  [3];
    bit eov  [3];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // 0 = delimiter, 1 = letter, 2 = digit
    function automatic int classify(input logic [7:0] c, input bit allow_us);
        if ((c >= "A" && c <= "Z") || (c >= "a" && c <= "z")) return 1;
        if (c == "_") return allow_us ? 1 : 0;
        if (c >= "0" && c <= "9") return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            wlen[k] = 0; ident[k] = 1'b0; etl[k] = 0;
            eid[k] = 1'b0; etv[k] = 1'b0; eov[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] c);
        for (int k = 0; k < 3; k++) begin
            int cl;
            eid[k] = 1'b0; etv[k] = 1'b0; eov[k] = 1'b0;
            if (v) begin
                cl = classify(c, us[k]);
                if (cl == 0) begin
                    if (wlen[k] > 0 && ident[k] && wlen[k] <= maxl[k]) begin
                        etv[k] = 1'b1;
                        etl[k] = wlen[k];
                    end
                    wlen[k] = 0;
                end else begin
                    if (wlen[k] == 0) ident[k] = (cl == 1);
                    wlen[k]++;
                    if (ident[k] && wlen[k] == maxl[k] + 1) eov[k] = 1'b1;
                    if (ident[k] && cl == 2 && wlen[k] <= maxl[k]) eid[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " a.id_digit"},  int'(if_a.id_digit),  int'(eid[0]));
        chk({tag, " a.tok_valid"}, int'(if_a.tok_valid), int'(etv[0]));
        chk({tag, " a.tok_len"},   int'(if_a.tok_len),   etl[0]);
        chk({tag, " a.tok_ovf"},   int'(if_a.tok_ovf),   int'(eov[0]));
        chk({tag, " b.id_digit"},  int'(if_b.id_digit),  int'(eid[1]));
        chk({tag, " b.tok_valid"}, int'(if_b.tok_valid), int'(etv[1]));
        chk({tag, " b.tok_len"},   int'(if_b.tok_len),   etl[1]);
        chk({tag, " b.tok_ovf"},   int'(if_b.tok_ovf),   int'(eov[1]));
        chk({tag, " c.id_digit"},  int'(if_c.id_digit),  int'(eid[2]));
        chk({tag, " c.tok_valid"}, int'(if_c.tok_valid), int'(etv[2]));
        chk({tag, " c.tok_len"},   int'(if_c.tok_len),   etl[2]);
        chk({tag, " c.tok_ovf"},   int'(if_c.tok_ovf),   int'(eov[2]));
    endtask

    task automatic drive(input bit v, input logic [7:0] c);
        if_a.in_valid = v; if_a.char = c;
        if_b.in_valid = v; if_b.char = c;
        if_c.in_valid = v; if_c.char = c;
    endtask

    task automatic cycle(input string tag, input bit v, input logic [7:0] c);
        drive(v, c);
        model_step(v, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send_str(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) cycle(tag, 1'b1, s[i]);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, " async"});
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 1) return 8'($urandom_range(8'h61, 8'h7A));
        if (r <= 3) return 8'($urandom_range(8'h41, 8'h5A));
        if (r <= 5) return 8'($urandom_range(8'h30, 8'h39));
        if (r == 6) return 8'h5F;
        if (r <= 8) return 8'h20;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        reset = 1'b1;
        drive(1'b1, "a");
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        #1;

        send_str("ab12", "ab12 ");
        send_str("num", "9ab ");
        send_str("ovf", "abcde1 ");
        send_str("after_ovf", "q ");
        send_str("underscore", "a_b ");

        send_str("gap", "ab");
        for (int i = 0; i < 3; i++) cycle("gap_idle", 1'b0, rand_char());
        send_str("gap_end", " ");

        send_str("rst_mid", "abc");
        reset_pulse("rst_mid");
        send_str("rst_after", " x ");

        send_str("long", "abcdefghijklmnop ");
        send_str("long_ovf", "abcdefghijklmnopq7 ");

        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                int wl = $urandom_range(13, 20);
                for (int i = 0; i < wl; i++) cycle("rnd_long", 1'b1, 8'($urandom_range(8'h61, 8'h7A)));
            end
            if ($urandom_range(0, 499) == 0) reset_pulse("rnd_rst");
            cycle("rnd", $urandom_range(0, 9) != 0, rand_char());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
